secuenciador_gray: RTL and testbench
====================================

Name: secuenciador_gray

Overview:
4-bit Gray-code step sequencer. It owns a binary step counter and a programmable rate prescaler. It steps up or down continuously or one step at a time, and registers both the binary index and its Gray equivalent. It drives Gray-coded position outputs (stepper phases, encoder emulation, CDC pointers) so that only one output bit changes per step, including at wrap-around.

Parameters:
DIV_W, 16, width of the prescaler divisor and counter.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
habilitar  input  1  master enable for continuous mode.
modo_continuo  input  1  1 = free-run at prescaled rate; 0 = single-step only.
paso  input  1  single-step request; acts on its rising edge.
sentido  input  1  1 = count up, 0 = count down; sampled at each step instant.
divisor  input  DIV_W  steps occur every divisor+1 clocks in continuous mode.
limite_en  input  1  enable the stop-at-limit comparison.
limite  input  4  binary index at which continuous mode stops.
cargar  input  1  synchronous load of valor_carga.
valor_carga  input  4  binary index loaded when cargar=1.
binario  output  4  registered binary index.
gray  output  4  registered Gray code of binario.
tick_paso  output  1  one-cycle pulse in the cycle after each step.
ocupado  output  1  1 while in state CORRIENDO.
fin  output  1  one-cycle pulse when a step lands on limite.

Behaviour:
- Reset (rst=1 at a clock edge):
  - binario=0, gray=0, tick_paso=0, fin=0, ocupado=0.
  - State=REPOSO; prescaler=0; paso edge register=0.
  - rst overrides every other input.
- Invariant: gray == binario ^ (binario>>1) in every cycle.
  - gray is registered from the next binary value in the same edge as binario, so there is no skew cycle.
- Step rule:
  - Up: binario+1 mod 16 (15->0).
  - Down: binario-1 mod 16 (0->15).
  - gray changes exactly one bit per step, including on wrap.
  - tick_paso=1 for exactly the cycle after each step edge.
- Priority per cycle: rst > cargar > state logic.
- cargar=1, in any state:
  - binario=valor_carga; gray=its Gray code.
  - Prescaler cleared; state->REPOSO; no tick_paso, no fin.
- paso rising edge: detected as paso=1 with previous-cycle paso=0. Held paso gives one step only.
- States:
  - REPOSO (ocupado=0):
    - paso edge -> one step; stays REPOSO.
    - habilitar=1 & modo_continuo=1 -> CORRIENDO, prescaler=0. Checked before paso: if both hold in the same cycle, enter CORRIENDO and do not step.
  - CORRIENDO (ocupado=1):
    - Prescaler increments each cycle.
    - When prescaler >= divisor: step and clear the prescaler. Uses >=, so lowering divisor mid-run steps on the next cycle.
    - divisor=0 -> one step every cycle.
    - The first step occurs divisor+1 cycles after entry.
    - paso is ignored.
    - habilitar=0 or modo_continuo=0 -> REPOSO; prescaler cleared; no step in that cycle.
    - limite_en=1 and the step result == limite -> LIMITE; fin=1 for the following cycle. Only step results are compared; entering CORRIENDO with binario==limite does not stop.
  - LIMITE (ocupado=0):
    - Outputs hold; paso is ignored.
    - habilitar=0 -> REPOSO.
    - cargar exits per the priority rule.
- Simultaneous step and limite_en deassert: evaluate limite_en in the same cycle as the step.
- Reset mid-run: aborts within one edge; no tick_paso or fin is emitted.
- Implementation: no latches; all outputs are registered.

Decomposition:
- Package secuenciador_gray_pkg:
  - State encoding localparams REPOSO=2'd0, CORRIENDO=2'd1, LIMITE=2'd2.
  - Binary->Gray function bin_a_gray(4-bit).
- Sub-module prescaler_tick (DIV_W): counter, clear input, divisor input, tick output (>= compare).
- FSM, step counter and paso edge detector live in the top level.

Test Plan:
1. Reset, then 16 paso pulses with sentido=1 and gap 3 -> binario 1..15,0; gray 0001,0011,0010,0110,...,1000,0000; one tick_paso each; Hamming distance 1 per step.
2. cargar valor_carga=0, sentido=0, modo_continuo=1, habilitar=1, divisor=2 -> ocupado=1; steps every 3 clocks; binario 15 (gray 1000) at the first step, then 14 (1001).
3. cargar 4'd3 with limite_en=1, limite=7, divisor=0, up, continuous -> binario 4,5,6,7 on consecutive cycles; fin one cycle after reaching 7; state LIMITE; binario holds 7; a paso pulse has no effect.
4. paso held high 10 cycles in REPOSO -> exactly one step. cargar=1 with a paso edge in the same cycle -> binario=valor_carga, no tick_paso.
5. Running at divisor=100 with prescaler at 50, set divisor=10 -> step on the next cycle, then every 11 cycles.
6. rst asserted mid-run at binario=9 -> next cycle binario=0, gray=0, ocupado=0, tick_paso=0, fin=0; no further steps until re-enabled.

Source files
------------

// File: rtl/secuenciador_gray_pkg.sv
// Shared types and helpers for the Gray-code step sequencer.
package secuenciador_gray_pkg;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CORRIENDO = 2'd1,
        LIMITE    = 2'd2
    } estado_t;

    function automatic logic [3:0] bin_a_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/secuenciador_gray_prescaler_tick.sv
// Rate prescaler: counts while enabled and flags when the count reaches the divisor.
module prescaler_tick
    import secuenciador_gray_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_divisor,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    // >= so that lowering the divisor mid-count fires on the next cycle
    assign o_tick = (r_cnt >= i_divisor);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/secuenciador_gray.sv
// 4-bit Gray-code step sequencer with single-step, free-run and stop-at-limit modes.
//   state     | meaning
//   REPOSO    | idle; single steps on paso edge
//   CORRIENDO | free-running at the prescaled rate
//   LIMITE    | stopped after landing on limite
module secuenciador_gray
    import secuenciador_gray_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_habilitar,
    input  logic             i_modo_continuo,
    input  logic             i_paso,
    input  logic             i_sentido,
    input  logic [DIV_W-1:0] i_divisor,
    input  logic             i_limite_en,
    input  logic [3:0]       i_limite,
    input  logic             i_cargar,
    input  logic [3:0]       i_valor_carga,
    output logic [3:0]       o_binario,
    output logic [3:0]       o_gray,
    output logic             o_tick_paso,
    output logic             o_ocupado,
    output logic             o_fin
);

    estado_t    r_estado;
    estado_t    w_estado_sig;
    logic [3:0] r_bin;
    logic [3:0] r_gray;
    logic       r_tick;
    logic       r_fin;
    logic       r_ocupado;
    logic       r_paso_prev;

    logic       w_paso_flanco;
    logic [3:0] w_bin_paso;
    logic [3:0] w_bin_sig;
    logic       w_paso;
    logic       w_fin;
    logic       w_pre_clr;
    logic       w_pre_en;
    logic       w_pre_tick;

    prescaler_tick #(.DIV_W(DIV_W)) u_prescaler (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_pre_clr),
        .i_en      (w_pre_en),
        .i_divisor (i_divisor),
        .o_tick    (w_pre_tick)
    );

    assign w_paso_flanco = i_paso & ~r_paso_prev;
    assign w_bin_paso    = i_sentido ? r_bin + 4'd1 : r_bin - 4'd1;

    always_comb begin
        w_estado_sig = r_estado;
        w_bin_sig    = r_bin;
        w_paso       = 1'b0;
        w_fin        = 1'b0;
        w_pre_clr    = 1'b0;
        w_pre_en     = 1'b0;
        if (i_cargar) begin
            w_estado_sig = REPOSO;
            w_bin_sig    = i_valor_carga;
            w_pre_clr    = 1'b1;
        end else begin
            case (r_estado)
                REPOSO: begin
                    // entering free-run wins over a coincident paso edge
                    if (i_habilitar && i_modo_continuo) begin
                        w_estado_sig = CORRIENDO;
                        w_pre_clr    = 1'b1;
                    end else if (w_paso_flanco) begin
                        w_paso    = 1'b1;
                        w_bin_sig = w_bin_paso;
                    end
                end
                CORRIENDO: begin
                    if (!i_habilitar || !i_modo_continuo) begin
                        w_estado_sig = REPOSO;
                        w_pre_clr    = 1'b1;
                    end else begin
                        w_pre_en = 1'b1;
                        if (w_pre_tick) begin
                            w_paso    = 1'b1;
                            w_bin_sig = w_bin_paso;
                            if (i_limite_en && (w_bin_paso == i_limite)) begin
                                w_estado_sig = LIMITE;
                                w_fin        = 1'b1;
                            end
                        end
                    end
                end
                LIMITE: begin
                    if (!i_habilitar) begin
                        w_estado_sig = REPOSO;
                    end
                end
                default: begin
                    w_estado_sig = REPOSO;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_estado    <= REPOSO;
            r_bin       <= 4'd0;
            r_gray      <= 4'd0;
            r_tick      <= 1'b0;
            r_fin       <= 1'b0;
            r_ocupado   <= 1'b0;
            r_paso_prev <= 1'b0;
        end else begin
            r_estado    <= w_estado_sig;
            r_bin       <= w_bin_sig;
            r_gray      <= bin_a_gray(w_bin_sig);
            r_tick      <= w_paso;
            r_fin       <= w_fin;
            r_ocupado   <= (w_estado_sig == CORRIENDO);
            r_paso_prev <= i_paso;
        end
    end

    assign o_binario   = r_bin;
    assign o_gray      = r_gray;
    assign o_tick_paso = r_tick;
    assign o_ocupado   = r_ocupado;
    assign o_fin       = r_fin;

endmodule

// File: tb/tb_secuenciador_gray.sv
// Directed scoreboard bench for secuenciador_gray: expected steps are queued and checked on each tick_paso.
module tb_secuenciador_gray;

    logic        clk = 1'b0;
    logic        rst;
    logic        habilitar, modo_continuo, paso, sentido;
    logic [15:0] divisor;
    logic        limite_en;
    logic [3:0]  limite;
    logic        cargar;
    logic [3:0]  valor_carga;
    logic [3:0]  binario, gray;
    logic        tick_paso, ocupado, fin;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_tick = 0;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gry;
        logic       fn;
        int         gap;
    } exp_t;
    exp_t sb[$];

    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    secuenciador_gray #(.DIV_W(16)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_habilitar     (habilitar),
        .i_modo_continuo (modo_continuo),
        .i_paso          (paso),
        .i_sentido       (sentido),
        .i_divisor       (divisor),
        .i_limite_en     (limite_en),
        .i_limite        (limite),
        .i_cargar        (cargar),
        .i_valor_carga   (valor_carga),
        .o_binario       (binario),
        .o_gray          (gray),
        .o_tick_paso     (tick_paso),
        .o_ocupado       (ocupado),
        .o_fin           (fin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int b, input logic f, input int gap);
        exp_t e;
        e.bin = 4'(b);
        e.gry = gtab[b];
        e.fn  = f;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // scoreboard consumer: every tick_paso must match the next queued step
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (tick_paso) begin
            chk("tick_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("step_bin", int'(binario), int'(e.bin));
                chk("step_gray", int'(gray), int'(e.gry));
                chk("step_fin", int'(fin), int'(e.fn));
                if (e.gap != 0) chk("step_gap", cyc - last_tick, e.gap);
            end
            last_tick = cyc;
        end else if (fin) begin
            chk("fin_without_tick", int'(fin), 0);
        end
    end

    initial begin
        rst = 1'b1; habilitar = 1'b0; modo_continuo = 1'b0; paso = 1'b0; sentido = 1'b1;
        divisor = 16'd0; limite_en = 1'b0; limite = 4'd0; cargar = 1'b0; valor_carga = 4'd0;
        go(2);
        chk("rst_bin", int'(binario), 0);
        chk("rst_gray", int'(gray), 0);
        chk("rst_tick", int'(tick_paso), 0);
        chk("rst_fin", int'(fin), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        rst = 1'b0;
        go(1);

        // 1: sixteen single steps upward through the wrap
        for (int i = 0; i < 16; i++) push((i + 1) % 16, 1'b0, (i == 0) ? 0 : 4);
        for (int i = 0; i < 16; i++) begin
            paso = 1'b1; go(1);
            paso = 1'b0; go(3);
        end
        chk("t1_bin_end", int'(binario), 0);
        chk("t1_sb_drained", sb.size(), 0);

        // 2: continuous downward from 0, divisor 2
        push(15, 1'b0, 0);
        push(14, 1'b0, 3);
        cargar = 1'b1; valor_carga = 4'd0; sentido = 1'b0; modo_continuo = 1'b1;
        habilitar = 1'b1; divisor = 16'd2;
        go(1);
        cargar = 1'b0;
        go(1);
        chk("t2_ocupado", int'(ocupado), 1);
        chk("t2_bin_entry", int'(binario), 0);
        go(2);
        chk("t2_bin_prestep", int'(binario), 0);
        go(4);
        chk("t2_bin_second", int'(binario), 14);
        habilitar = 1'b0;
        go(1);
        chk("t2_ocupado_off", int'(ocupado), 0);
        go(3);
        chk("t2_bin_hold", int'(binario), 14);
        chk("t2_sb_drained", sb.size(), 0);

        // 3: stop at limit 7 from 3 at full rate
        push(4, 1'b0, 0);
        push(5, 1'b0, 1);
        push(6, 1'b0, 1);
        push(7, 1'b1, 1);
        cargar = 1'b1; valor_carga = 4'd3; limite_en = 1'b1; limite = 4'd7;
        divisor = 16'd0; sentido = 1'b1; modo_continuo = 1'b1; habilitar = 1'b1;
        go(1);
        cargar = 1'b0;
        go(5);
        chk("t3_bin_lim", int'(binario), 7);
        chk("t3_fin", int'(fin), 1);
        chk("t3_ocupado_lim", int'(ocupado), 0);
        go(1);
        chk("t3_fin_pulse", int'(fin), 0);
        paso = 1'b1; go(1);
        paso = 1'b0; go(3);
        chk("t3_bin_held", int'(binario), 7);
        chk("t3_still_limite", int'(ocupado), 0);
        habilitar = 1'b0; limite_en = 1'b0;
        go(1);
        chk("t3_sb_drained", sb.size(), 0);

        // 4: held paso gives one step; load beats a paso edge
        push(8, 1'b0, 0);
        paso = 1'b1; go(10);
        paso = 1'b0; go(2);
        chk("t4_bin_one_step", int'(binario), 8);
        chk("t4_sb_drained", sb.size(), 0);
        paso = 1'b1; cargar = 1'b1; valor_carga = 4'd12;
        go(1);
        chk("t4_load_bin", int'(binario), 12);
        chk("t4_load_gray", int'(gray), int'(4'b1010));
        chk("t4_load_tick", int'(tick_paso), 0);
        cargar = 1'b0; paso = 1'b0;
        go(2);
        chk("t4_bin_after", int'(binario), 12);

        // 5: lowering divisor mid-count
        push(13, 1'b0, 0);
        push(14, 1'b0, 11);
        push(15, 1'b0, 11);
        divisor = 16'd100; sentido = 1'b1; modo_continuo = 1'b1; habilitar = 1'b1;
        go(1);
        chk("t5_ocupado", int'(ocupado), 1);
        go(50);
        chk("t5_bin_before", int'(binario), 12);
        divisor = 16'd10;
        go(1);
        chk("t5_bin_next", int'(binario), 13);
        go(22);
        chk("t5_bin_third", int'(binario), 15);
        habilitar = 1'b0;
        go(3);
        chk("t5_sb_drained", sb.size(), 0);

        // 6: reset mid-run
        push(9, 1'b0, 0);
        cargar = 1'b1; valor_carga = 4'd8; divisor = 16'd3; habilitar = 1'b1;
        modo_continuo = 1'b1; sentido = 1'b1;
        go(1);
        cargar = 1'b0;
        go(5);
        chk("t6_bin_9", int'(binario), 9);
        rst = 1'b1;
        go(1);
        chk("t6_rst_bin", int'(binario), 0);
        chk("t6_rst_gray", int'(gray), 0);
        chk("t6_rst_ocupado", int'(ocupado), 0);
        chk("t6_rst_tick", int'(tick_paso), 0);
        chk("t6_rst_fin", int'(fin), 0);
        rst = 1'b0; habilitar = 1'b0;
        go(10);
        chk("t6_bin_idle", int'(binario), 0);
        chk("t6_ocupado_idle", int'(ocupado), 0);
        chk("t6_sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
